// File: rtl/pc_next_reg.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_reg
// Brief    : Fetch-stage PC register with redirect selection, stall handling
//            and a one-entry pending-redirect buffer.
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [31:0]      EXC_VEC   = 32'h8000_0180,
    parameter int               INC       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             StallF,
    input  logic [1:0]       PCSrcD,
    input  logic [WIDTH-1:0] PCBranchD,
    input  logic [WIDTH-1:0] PCJumpD,
    input  logic [WIDTH-1:0] PCJrD,
    input  logic             ExcF,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] PCPlus4F,
    output logic             PendF,
    output logic             MisalignF
);

    localparam logic [WIDTH-1:0] c_exc_vec = WIDTH'(EXC_VEC);
    localparam logic [WIDTH-1:0] c_inc     = WIDTH'(INC);

    logic [WIDTH-1:0] r_pc;
    logic             r_pend;
    logic [WIDTH-1:0] r_pend_tgt;

    logic [WIDTH-1:0] w_live_tgt;
    logic [WIDTH-1:0] w_pc_nxt;
    logic             w_pend_nxt;
    logic [WIDTH-1:0] w_pend_tgt_nxt;
    logic [WIDTH-1:0] w_pc_plus;

    assign w_pc_plus = r_pc + c_inc;

    always_comb begin
        case (PCSrcD)
            2'b01:   w_live_tgt = PCBranchD;
            2'b10:   w_live_tgt = PCJumpD;
            default: w_live_tgt = PCJrD;
        endcase
    end

    // Priority: exception, stall, pending redirect, live redirect, sequential.
    always_comb begin
        w_pc_nxt       = r_pc;
        w_pend_nxt     = r_pend;
        w_pend_tgt_nxt = r_pend_tgt;
        if (ExcF) begin
            w_pc_nxt   = c_exc_vec;
            w_pend_nxt = 1'b0;
        end else if (StallF) begin
            // Only the first redirect of a stall is kept; the stalled decode
            // instruction keeps re-presenting the same request afterwards.
            if (!r_pend && (PCSrcD != 2'b00)) begin
                w_pend_tgt_nxt = w_live_tgt;
                w_pend_nxt     = 1'b1;
            end
        end else if (r_pend) begin
            w_pc_nxt   = r_pend_tgt;
            w_pend_nxt = 1'b0;
        end else if (PCSrcD != 2'b00) begin
            w_pc_nxt = w_live_tgt;
        end else begin
            w_pc_nxt = w_pc_plus;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_VEC;
            r_pend     <= 1'b0;
            r_pend_tgt <= '0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
        end
    end

    assign PCF       = r_pc;
    assign PCPlus4F  = w_pc_plus;
    assign PendF     = r_pend;
    assign MisalignF = |r_pc[1:0];

endmodule
`default_nettype wire

// File: tb/tb_pc_next_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_next_reg
// Brief    : Scoreboard bench for pc_next_reg (32-bit and 8-bit instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_next_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  src;
    logic [31:0] br, jmp, jr;
    logic        exc;

    logic [31:0] pcf32, pcp32;
    logic        pend32, mis32;
    logic [7:0]  pcf8, pcp8;
    logic        pend8, mis8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint pc32;
        bit     pend32;
        longint pc8;
        bit     pend8;
    } exp_t;

    exp_t sb[$];

    // reference state
    longint m_pc32, m_tgt32, m_pc8, m_tgt8;
    bit     m_pend32, m_pend8;

    always #5 clk = ~clk;

    pc_next_reg #(.WIDTH(32), .RESET_VEC(32'h0), .EXC_VEC(32'h8000_0180), .INC(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .StallF(stall), .PCSrcD(src),
        .PCBranchD(br), .PCJumpD(jmp), .PCJrD(jr), .ExcF(exc),
        .PCF(pcf32), .PCPlus4F(pcp32), .PendF(pend32), .MisalignF(mis32)
    );

    pc_next_reg #(.WIDTH(8), .RESET_VEC(8'h0), .EXC_VEC(32'h8000_0180), .INC(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .StallF(stall), .PCSrcD(src),
        .PCBranchD(br[7:0]), .PCJumpD(jmp[7:0]), .PCJrD(jr[7:0]), .ExcF(exc),
        .PCF(pcf8), .PCPlus4F(pcp8), .PendF(pend8), .MisalignF(mis8)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model(input longint mask, input longint excv,
                         inout longint pc, inout bit pend, inout longint tgt);
        longint t;
        t = (src == 2'd1) ? longint'(br) : (src == 2'd2) ? longint'(jmp) : longint'(jr);
        t = t & mask;
        if (exc) begin
            pc   = excv & mask;
            pend = 1'b0;
        end else if (stall) begin
            if (!pend && src != 2'd0) begin
                tgt  = t;
                pend = 1'b1;
            end
        end else if (pend) begin
            pc   = tgt;
            pend = 1'b0;
        end else if (src != 2'd0) begin
            pc = t;
        end else begin
            pc = (pc + 4) % (mask + 1);
        end
    endtask

    task automatic model_reset();
        m_pc32 = 0; m_pend32 = 1'b0; m_tgt32 = 0;
        m_pc8  = 0; m_pend8  = 1'b0; m_tgt8  = 0;
    endtask

    // Called at a falling edge; drives one cycle of stimulus and queues the
    // expected post-edge state, then returns at the next falling edge.
    task automatic step(input bit s, input logic [1:0] sr, input logic [31:0] b,
                        input logic [31:0] j, input logic [31:0] r, input bit e);
        exp_t x;
        stall = s; src = sr; br = b; jmp = j; jr = r; exc = e;
        model(64'hFFFF_FFFF, 64'h8000_0180, m_pc32, m_pend32, m_tgt32);
        model(64'hFF,        64'h8000_0180, m_pc8,  m_pend8,  m_tgt8);
        x.pc32 = m_pc32; x.pend32 = m_pend32; x.pc8 = m_pc8; x.pend8 = m_pend8;
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    // Monitor: outputs are valid every cycle, so compare once per rising edge.
    always begin
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            exp_t x;
            x = sb.pop_front();
            chk("pcf32",  longint'(pcf32), x.pc32);
            chk("pend32", longint'(pend32), longint'(x.pend32));
            chk("pcp32",  longint'(pcp32), (x.pc32 + 4) % 64'h1_0000_0000);
            chk("mis32",  longint'(mis32), longint'((x.pc32 & 3) != 0));
            chk("pcf8",   longint'(pcf8), x.pc8);
            chk("pend8",  longint'(pend8), longint'(x.pend8));
            chk("pcp8",   longint'(pcp8), (x.pc8 + 4) % 256);
            chk("mis8",   longint'(mis8), longint'((x.pc8 & 3) != 0));
        end
    end

    initial begin
        int waited;
        rst_n = 1'b0; stall = 1'b0; src = 2'd0; br = '0; jmp = '0; jr = '0; exc = 1'b0;
        model_reset();
        #2;
        chk("rst_pcf32", longint'(pcf32), 0);
        chk("rst_pend32", longint'(pend32), 0);
        chk("rst_pcf8", longint'(pcf8), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // sequential fetch
        repeat (3) idle();
        // branch and jump-register
        step(1'b0, 2'd2, 32'h0, 32'h10, 32'h0, 1'b0);
        step(1'b0, 2'd1, 32'h40, 32'h0, 32'h0, 1'b0);
        step(1'b0, 2'd3, 32'h0, 32'h0, 32'h100, 1'b0);
        // redirect during stall: first one wins
        step(1'b0, 2'd2, 32'h0, 32'h20, 32'h0, 1'b0);
        step(1'b1, 2'd2, 32'h0, 32'h200, 32'h0, 1'b0);
        step(1'b1, 2'd2, 32'h0, 32'h300, 32'h0, 1'b0);
        step(1'b1, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        idle();
        // pending squashes a live redirect on release
        step(1'b1, 2'd2, 32'h0, 32'h200, 32'h0, 1'b0);
        step(1'b0, 2'd1, 32'h80, 32'h0, 32'h0, 1'b0);
        // exception beats stall and pending
        step(1'b1, 2'd2, 32'h0, 32'h240, 32'h0, 1'b0);
        step(1'b1, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1);
        idle();
        // exception on the release edge with pending valid
        step(1'b1, 2'd3, 32'h0, 32'h0, 32'h1C, 1'b0);
        step(1'b0, 2'd1, 32'h44, 32'h0, 32'h0, 1'b1);
        // async reset mid-stall with pending valid
        step(1'b1, 2'd2, 32'h0, 32'h400, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pcf32", longint'(pcf32), 0);
        chk("arst_pend32", longint'(pend32), 0);
        chk("arst_pend8", longint'(pend8), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        // wrap and misalignment
        step(1'b0, 2'd2, 32'h0, 32'hFC, 32'h0, 1'b0);
        idle();
        step(1'b0, 2'd2, 32'h0, 32'h13, 32'h0, 1'b0);
        step(1'b0, 2'd2, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0);
        idle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)),
                 $urandom, $urandom, $urandom, ($urandom_range(0, 19) == 0));
        end

        waited = 0;
        while (sb.size() != 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d entries left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
